// File: rtl/lbm_pkg.sv
// Shared lattice-Boltzmann types: the nine-direction packed cell and the
// collision sequencer state encoding.
package lbm_pkg;

   localparam int NUM_DIRS = 9;

   localparam int DIR_C  = 0;
   localparam int DIR_N  = 1;
   localparam int DIR_NE = 2;
   localparam int DIR_E  = 3;
   localparam int DIR_SE = 4;
   localparam int DIR_S  = 5;
   localparam int DIR_SW = 6;
   localparam int DIR_W  = 7;
   localparam int DIR_NW = 8;

   typedef logic [NUM_DIRS-1:0][7:0] cell_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_DONE
   } seq_state_t;

endpackage

// File: rtl/delay_line.sv
// Fixed-depth shift register with asynchronous clear. msb_any reports whether
// any stage holds a set MSB, which callers use as the per-entry valid flag.
module delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk_in,
   input  logic             clr_in,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             msb_any
);

   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge clk_in or posedge clr_in) begin
      if (clr_in) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[DEPTH-1];

   always_comb begin
      msb_any = 1'b0;
      for (int i = 0; i < DEPTH; i++) msb_any = msb_any | stage[i][WIDTH-1];
   end

endmodule

// File: rtl/collide_sequencer.sv
// Walks every lattice cell once: reads BRAM, feeds the collision pipeline and
// writes each collided cell back to the address it was read from.
//
// state    | meaning
// IDLE     | waiting for start_in
// ISSUE    | one BRAM read per cycle, addresses 0..NUM_CELLS-1
// DRAIN    | reads finished, waiting for the last write-back
// DONE     | one-cycle done_out pulse
module collide_sequencer
   import lbm_pkg::*;
#(
   parameter int NUM_CELLS         = 4800,
   parameter int ADDR_WIDTH        = $clog2(NUM_CELLS),
   parameter int BRAM_READ_LATENCY = 2,
   parameter int COLLIDE_LATENCY   = 20
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  start_in,
   output logic                  busy_out,
   output logic                  done_out,
   output logic                  rd_en_out,
   output logic [ADDR_WIDTH-1:0] rd_addr_out,
   input  cell_t                 rd_data_in,
   output cell_t                 collide_data_out,
   output logic                  collide_valid_out,
   input  cell_t                 collide_result_in,
   output logic                  wr_en_out,
   output logic [ADDR_WIDTH-1:0] wr_addr_out,
   output cell_t                 wr_data_out
);

   localparam int TRK_DEPTH = BRAM_READ_LATENCY + 1 + COLLIDE_LATENCY;
   localparam int CNT_W     = $clog2(TRK_DEPTH + 2);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_CELLS - 1);

   seq_state_t            state, state_nxt;
   logic [ADDR_WIDTH-1:0] rd_cnt;
   logic [CNT_W-1:0]      outstanding;
   logic                  rd_issue;
   logic                  rd_vld_tap, rd_vld_any;
   logic                  trk_vld, trk_any;
   logic [ADDR_WIDTH-1:0] trk_addr;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      rd_issue  = 1'b0;
      busy_out  = 1'b0;
      done_out  = 1'b0;
      case (state)
         ST_IDLE: if (start_in) state_nxt = ST_ISSUE;
         ST_ISSUE: begin
            rd_issue = 1'b1;
            busy_out = 1'b1;
            if (rd_cnt == LAST_ADDR) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            busy_out = 1'b1;
            if (outstanding == '0 && !trk_any && !rd_vld_any) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done_out  = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign rd_en_out   = rd_issue;
   assign rd_addr_out = rd_cnt;

   // Holds at the last address so the counter never wraps within a pass.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)                                rd_cnt <= '0;
      else if (state == ST_IDLE && start_in)     rd_cnt <= '0;
      else if (rd_issue && rd_cnt != LAST_ADDR)  rd_cnt <= rd_cnt + 1'b1;
   end

   // A write is counted when its tap is seen, so the count reaches zero in
   // time for done_out to follow the final write-back by one cycle.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         outstanding <= '0;
      end else begin
         case ({rd_issue, trk_vld})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
      end
   end

   delay_line #(.WIDTH(1), .DEPTH(BRAM_READ_LATENCY)) u_rd_align (
      .clk_in  (clk_in),
      .clr_in  (rst_in),
      .din     (rd_issue),
      .dout    (rd_vld_tap),
      .msb_any (rd_vld_any)
   );

   delay_line #(.WIDTH(ADDR_WIDTH + 1), .DEPTH(TRK_DEPTH)) u_addr_trk (
      .clk_in  (clk_in),
      .clr_in  (rst_in),
      .din     ({rd_issue, rd_cnt}),
      .dout    ({trk_vld, trk_addr}),
      .msb_any (trk_any)
   );

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         collide_valid_out <= 1'b0;
         collide_data_out  <= '0;
         wr_en_out         <= 1'b0;
         wr_addr_out       <= '0;
         wr_data_out       <= '0;
      end else begin
         collide_valid_out <= rd_vld_tap;
         collide_data_out  <= rd_vld_tap ? rd_data_in : '0;
         wr_en_out         <= trk_vld;
         wr_addr_out       <= trk_vld ? trk_addr : '0;
         wr_data_out       <= trk_vld ? collide_result_in : '0;
      end
   end

endmodule

// File: tb/tb_collide_sequencer.sv
// Bench for collide_sequencer: four instances covering latency and lattice-size
// corners, each with a BRAM/collision stub and a write-back monitor.
module tb_collide_sequencer;
   import lbm_pkg::*;

   logic clk_in = 1'b0;
   logic rst_in, start_in, mon_clr;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   s0 = 0;

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   function automatic cell_t pattern(int a, int inc);
      cell_t r;
      for (int d = 0; d < NUM_DIRS; d++) r[d] = 8'(a * 9 + d + inc);
      return r;
   endfunction

   function automatic cell_t add1(cell_t c);
      cell_t r;
      for (int d = 0; d < NUM_DIRS; d++) r[d] = c[d] + 8'd1;
      return r;
   endfunction

   function automatic int f_n(int g);  return (g == 3) ? 4800 : 8; endfunction
   function automatic int f_lr(int g); return (g == 1 || g == 2) ? 1 : 2; endfunction
   function automatic int f_lc(int g); return (g == 1) ? 37 : (g == 2) ? 1 : 20; endfunction

   int   m_wcnt [4];
   int   m_rcnt [4];
   int   m_ccnt [4];
   int   m_dcnt [4];
   int   m_first [4];
   int   m_last [4];
   int   m_done [4];
   int   m_errs [4];
   int   m_maxo [4];
   logic m_any [4];

   for (genvar g = 0; g < 4; g++) begin : gen
      localparam int N   = (g == 3) ? 4800 : 8;
      localparam int AW  = $clog2(N);
      localparam int LRG = (g == 1 || g == 2) ? 1 : 2;
      localparam int LCG = (g == 1) ? 37 : (g == 2) ? 1 : 20;

      logic          busy, done, rd_en, cv, wr_en;
      logic [AW-1:0] rd_addr, wr_addr;
      cell_t         rd_data, cd, cres, wd;

      collide_sequencer #(
         .NUM_CELLS(N), .BRAM_READ_LATENCY(LRG), .COLLIDE_LATENCY(LCG)
      ) u_dut (
         .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
         .busy_out(busy), .done_out(done),
         .rd_en_out(rd_en), .rd_addr_out(rd_addr), .rd_data_in(rd_data),
         .collide_data_out(cd), .collide_valid_out(cv), .collide_result_in(cres),
         .wr_en_out(wr_en), .wr_addr_out(wr_addr), .wr_data_out(wd)
      );

      // BRAM stub: every cell holds byte = addr*9+dir
      logic [AW-1:0] ra_q [LRG];
      always @(posedge clk_in) begin
         ra_q[0] <= rd_addr;
         for (int i = 1; i < LRG; i++) ra_q[i] <= ra_q[i-1];
      end
      assign rd_data = pattern(int'(ra_q[LRG-1]), 0);

      // collision stub: +1 on every byte after LCG cycles
      cell_t cq [LCG];
      always @(posedge clk_in) begin
         cq[0] <= add1(cd);
         for (int i = 1; i < LCG; i++) cq[i] <= cq[i-1];
      end
      assign cres = cq[LCG-1];

      int wcnt = 0, rcnt = 0, ccnt = 0, dcnt = 0, first_wr = -1, last_wr = 0;
      int done_cyc = 0, errs = 0, max_out = 0;
      always @(negedge clk_in) begin
         if (mon_clr) begin
            wcnt <= 0; rcnt <= 0; ccnt <= 0; dcnt <= 0; first_wr <= -1;
            last_wr <= 0; done_cyc <= 0; errs <= 0; max_out <= 0;
         end else begin
            errs <= errs
                  + int'(rd_en && rd_addr != AW'(rcnt % N))
                  + int'(cv && cd != pattern(ccnt % N, 0))
                  + int'(wr_en && (wr_addr != AW'(wcnt % N) || wd != pattern(wcnt % N, 1)));
            if (rd_en) rcnt <= rcnt + 1;
            if (cv) ccnt <= ccnt + 1;
            if (wr_en) begin
               wcnt <= wcnt + 1;
               if (first_wr < 0) first_wr <= cyc;
               last_wr <= cyc;
            end
            if (done) begin
               dcnt <= dcnt + 1;
               done_cyc <= cyc;
            end
            if (int'(u_dut.outstanding) > max_out) max_out <= int'(u_dut.outstanding);
         end
      end

      assign m_wcnt[g]  = wcnt;
      assign m_rcnt[g]  = rcnt;
      assign m_ccnt[g]  = ccnt;
      assign m_dcnt[g]  = dcnt;
      assign m_first[g] = first_wr;
      assign m_last[g]  = last_wr;
      assign m_done[g]  = done_cyc;
      assign m_errs[g]  = errs;
      assign m_maxo[g]  = max_out;
      assign m_any[g]   = busy | done | rd_en | cv | wr_en | (|rd_addr) | (|wr_addr)
                        | (|cd) | (|wd);
   end

   task automatic check(string name, longint act, longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic clear_monitors();
      mon_clr = 1'b1;
      step();
      mon_clr = 1'b0;
   endtask

   typedef struct {
      int         c;
      logic       busy, done, rd_en;
      logic [2:0] rd_addr;
      logic       cv, wr_en;
      logic [2:0] wr_addr;
   } vec_t;

   vec_t tv [15];

   initial begin
      logic [10:0] act_v, exp_v;

      tv = '{
         '{ 0, 0, 0, 0, 3'd0, 0, 0, 3'd0},
         '{ 1, 1, 0, 1, 3'd0, 0, 0, 3'd0},
         '{ 3, 1, 0, 1, 3'd2, 0, 0, 3'd0},
         '{ 4, 1, 0, 1, 3'd3, 1, 0, 3'd0},
         '{ 5, 1, 0, 1, 3'd4, 1, 0, 3'd0},
         '{ 8, 1, 0, 1, 3'd7, 1, 0, 3'd0},
         '{ 9, 1, 0, 0, 3'd0, 1, 0, 3'd0},
         '{11, 1, 0, 0, 3'd0, 1, 0, 3'd0},
         '{12, 1, 0, 0, 3'd0, 0, 0, 3'd0},
         '{24, 1, 0, 0, 3'd0, 0, 0, 3'd0},
         '{25, 1, 0, 0, 3'd0, 0, 1, 3'd0},
         '{26, 1, 0, 0, 3'd0, 0, 1, 3'd1},
         '{32, 1, 0, 0, 3'd0, 0, 1, 3'd7},
         '{33, 0, 1, 0, 3'd0, 0, 0, 3'd0},
         '{34, 0, 0, 0, 3'd0, 0, 0, 3'd0}
      };

      rst_in = 1'b1; start_in = 1'b0; mon_clr = 1'b1;
      repeat (3) step();
      for (int g = 0; g < 4; g++) check($sformatf("reset_outputs_zero[%0d]", g), m_any[g], 0);
      rst_in = 1'b0;
      step();

      // single pass, with a second start at cycle 5 that must be ignored
      mon_clr = 1'b0;
      s0 = cyc;
      for (int c = 0; c <= 36; c++) begin
         start_in = (c == 0 || c == 5);
         @(negedge clk_in);
         for (int r = 0; r < 15; r++) begin
            if (tv[r].c == c) begin
               act_v = {gen[0].busy, gen[0].done, gen[0].rd_en,
                        tv[r].rd_en ? gen[0].rd_addr : 3'd0, gen[0].cv, gen[0].wr_en,
                        tv[r].wr_en ? gen[0].wr_addr : 3'd0};
               exp_v = {tv[r].busy, tv[r].done, tv[r].rd_en, tv[r].rd_addr, tv[r].cv,
                        tv[r].wr_en, tv[r].wr_addr};
               check($sformatf("vector_cycle_%0d", c), act_v, exp_v);
            end
         end
         if (c == 4) check("collide_data_cell0", gen[0].cd, pattern(0, 0));
         if (c == 25) check("wr_data_cell0", gen[0].wd, pattern(0, 1));
         @(posedge clk_in);
         #1;
      end
      start_in = 1'b0;
      check("single_wr_count", m_wcnt[0], 8);
      check("single_first_wr", m_first[0] - s0, 25);
      check("single_last_wr", m_last[0] - s0, 32);
      check("single_done_count", m_dcnt[0], 1);
      check("single_done_cycle", m_done[0] - s0, 33);
      check("single_seq_errors", m_errs[0], 0);

      // back-to-back: start during done is ignored, start one cycle later runs
      clear_monitors();
      s0 = cyc;
      for (int c = 0; c <= 70; c++) begin
         start_in = (c == 0 || c == 33 || c == 34);
         step();
      end
      start_in = 1'b0;
      check("b2b_wr_count", m_wcnt[0], 16);
      check("b2b_done_count", m_dcnt[0], 2);
      check("b2b_first_wr", m_first[0] - s0, 25);
      check("b2b_last_wr", m_last[0] - s0, 34 + 32);
      check("b2b_done_cycle", m_done[0] - s0, 34 + 33);
      check("b2b_seq_errors", m_errs[0], 0);

      // reset mid-pass
      clear_monitors();
      for (int c = 0; c < 15; c++) begin
         start_in = (c == 0);
         step();
      end
      start_in = 1'b0;
      rst_in = 1'b1;
      mon_clr = 1'b1;
      #1;
      for (int g = 0; g < 4; g++) check($sformatf("midpass_reset_zero[%0d]", g), m_any[g], 0);
      step();
      step();
      rst_in = 1'b0;
      mon_clr = 1'b0;
      repeat (40) step();
      for (int g = 0; g < 4; g++) begin
         check($sformatf("post_reset_no_wr[%0d]", g), m_wcnt[g], 0);
         check($sformatf("post_reset_no_rd[%0d]", g), m_rcnt[g], 0);
      end

      // full pass on every instance: latency sweep and the 4800-cell lattice
      clear_monitors();
      s0 = cyc;
      start_in = 1'b1;
      step();
      start_in = 1'b0;
      repeat (4840) step();
      for (int g = 0; g < 4; g++) begin
         check($sformatf("full_wr_count[%0d]", g), m_wcnt[g], f_n(g));
         check($sformatf("full_rd_count[%0d]", g), m_rcnt[g], f_n(g));
         check($sformatf("full_cv_count[%0d]", g), m_ccnt[g], f_n(g));
         check($sformatf("full_done_count[%0d]", g), m_dcnt[g], 1);
         check($sformatf("full_first_wr[%0d]", g), m_first[g] - s0, f_lr(g) + f_lc(g) + 3);
         check($sformatf("full_last_wr[%0d]", g), m_last[g] - s0, f_n(g) + f_lr(g) + f_lc(g) + 2);
         check($sformatf("full_done_cycle[%0d]", g), m_done[g] - s0, f_n(g) + f_lr(g) + f_lc(g) + 3);
         check($sformatf("full_seq_errors[%0d]", g), m_errs[g], 0);
         check($sformatf("outstanding_within_depth[%0d]", g),
               int'(m_maxo[g] <= f_lr(g) + 1 + f_lc(g)), 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
